// File: rtl/key_expand_if.sv
// Key-load / round-key handshake bundle for key_expand.
// KEY_EXPAND_STORE_EN adds the stored-key read port (rd_addr/rd_key).
interface key_expand_if;
  localparam int SENTENCE = 128;

  logic                start;
  logic [SENTENCE-1:0] key;
  logic                busy;
  logic [SENTENCE-1:0] rk;
  logic [3:0]          rk_round;
  logic                rk_valid;
  logic                rk_ready;
  logic                done;
`ifdef KEY_EXPAND_STORE_EN
  logic [3:0]          rd_addr;
  logic [SENTENCE-1:0] rd_key;

  modport master (
    output start, key, rk_ready, rd_addr,
    input  busy, rk, rk_round, rk_valid, done, rd_key
  );
  modport slave (
    input  start, key, rk_ready, rd_addr,
    output busy, rk, rk_round, rk_valid, done, rd_key
  );
`else
  modport master (
    output start, key, rk_ready,
    input  busy, rk, rk_round, rk_valid, done
  );
  modport slave (
    input  start, key, rk_ready,
    output busy, rk, rk_round, rk_valid, done
  );
`endif
endinterface

// File: rtl/key_expand.sv
// Iterative AES-128 key schedule: emits round keys 0..10 over a valid/ready handshake.
// KEY_EXPAND_STORE_EN adds an 11-entry round-key store with a registered read port.
module key_expand (
  input  logic        clk,
  input  logic        rst,
  key_expand_if.slave bus
);
  localparam int BYTE     = 8;
  localparam int WORD     = 32;
  localparam int SENTENCE = 128;
  localparam int ROUNDS   = 10;

  localparam logic [BYTE-1:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [BYTE-1:0] sbox(input logic [BYTE-1:0] b);
    return SBOX[b];
  endfunction

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t              state, state_nx;
  logic [SENTENCE-1:0] rk_q, rk_nx;
  logic [3:0]          round_q;
  logic [BYTE-1:0]     rcon_q, rcon_nx;
  logic                valid_q;
  logic                accept, last;
  logic                load;

  logic [WORD-1:0] w0, w1, w2, w3, rot, t, n0, n1, n2, n3;

  assign accept = valid_q & bus.rk_ready;
  assign last   = (round_q == 4'(ROUNDS));
  assign load   = (state == IDLE) & bus.start;

  // Single SubWord on the rotated last word, then the chained XORs of the next round.
  always_comb begin
    {w0, w1, w2, w3} = rk_q;
    rot     = {w3[WORD-BYTE-1:0], w3[WORD-1:WORD-BYTE]};
    t       = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
              ^ {rcon_q, {(WORD-BYTE){1'b0}}};
    n0      = w0 ^ t;
    n1      = w1 ^ n0;
    n2      = w2 ^ n1;
    n3      = w3 ^ n2;
    rk_nx   = {n0, n1, n2, n3};
    rcon_nx = {rcon_q[BYTE-2:0], 1'b0} ^ (rcon_q[BYTE-1] ? 8'h1b : 8'h00);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = EXPAND;
      EXPAND:  if (accept && last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rk_q    <= '0;
      round_q <= '0;
      rcon_q  <= 8'h01;
      valid_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        rk_q    <= bus.key;
        round_q <= '0;
        rcon_q  <= 8'h01;
        valid_q <= 1'b1;
      end else if (accept) begin
        if (last) begin
          valid_q <= 1'b0;
        end else begin
          rk_q    <= rk_nx;
          round_q <= round_q + 4'd1;
          rcon_q  <= rcon_nx;
        end
      end
    end
  end

  assign bus.busy     = (state == EXPAND);
  assign bus.done     = (state == DONE);
  assign bus.rk       = rk_q;
  assign bus.rk_round = round_q;
  assign bus.rk_valid = valid_q;

`ifdef KEY_EXPAND_STORE_EN
  logic [SENTENCE-1:0] store [ROUNDS+1];
  logic [SENTENCE-1:0] rd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i <= ROUNDS; i++) store[i] <= '0;
      rd_q <= '0;
    end else begin
      if (accept) store[round_q] <= rk_q;
      rd_q <= (bus.rd_addr <= 4'(ROUNDS)) ? store[bus.rd_addr] : '0;
    end
  end

  assign bus.rd_key = rd_q;
`endif
endmodule

// File: tb/tb_key_expand.sv
// Self-checking bench for key_expand: FIPS-197 vectors, random keys/backpressure vs a
// FIPS-style reference schedule with an S-box derived from GF(2^8) inversion.
module tb_key_expand;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  key_expand_if kif ();
  key_expand dut (.clk(clk), .rst(rst), .bus(kif));

  int checks = 0;
  int errors = 0;

  logic [7:0]   sb_ref [256];
  logic [31:0]  mw [44];
  logic [127:0] exp_keys [11];
  logic [127:0] got_keys [11];
  int           last_cycles;

  typedef struct {
    logic [127:0] key;
    int           round;
    logic [127:0] expv;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d = {v, v} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      sb_ref[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Textbook schedule: w[i] = w[i-4] ^ (i%4==0 ? SubWord(RotWord(w[i-1]))^Rcon : w[i-1]).
  task automatic model_expand(input logic [127:0] k);
    logic [7:0]  rc = 8'h01;
    logic [31:0] tmp;
    for (int i = 0; i < 4; i++) mw[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = mw[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb_ref[tmp[31:24]], sb_ref[tmp[23:16]], sb_ref[tmp[15:8]], sb_ref[tmp[7:0]]};
        tmp ^= {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      mw[i] = mw[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) exp_keys[r] = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endtask

  // Runs one expansion; ready_pct sets backpressure, glitch pulses a foreign start at round 4.
  task automatic expand(input logic [127:0] k, input int ready_pct, input bit glitch);
    int idx = 0;
    int cycles = 0;
    bit stalled = 0;
    bit rdy;
    logic [127:0] prev_rk;
    logic [3:0] prev_round;
    model_expand(k);
    @(negedge clk);
    kif.start = 1'b1;
    kif.key   = k;
    @(negedge clk);
    kif.start = 1'b0;
    while (idx <= 10 && cycles < 300) begin
      rdy = ($urandom_range(99) < 32'(ready_pct));
      check("rk_valid", 128'(kif.rk_valid), 128'd1);
      check("busy", 128'(kif.busy), 128'd1);
      if (stalled) begin
        check("stall_rk", kif.rk, prev_rk);
        check("stall_round", 128'(kif.rk_round), 128'(prev_round));
      end
      check("rk_round", 128'(kif.rk_round), 128'(idx));
      if (glitch && idx == 4 && !stalled) begin
        kif.start = 1'b1;
        kif.key   = ~k;
      end else begin
        kif.start = 1'b0;
      end
      prev_rk = kif.rk;
      prev_round = kif.rk_round;
      if (rdy) begin
        check($sformatf("rk_r%0d", idx), kif.rk, exp_keys[idx]);
        got_keys[idx] = kif.rk;
        idx++;
      end
      stalled = !rdy;
      kif.rk_ready = rdy;
      @(negedge clk);
      cycles++;
    end
    kif.start = 1'b0;
    kif.rk_ready = 1'b0;
    check("expand_bound", 128'(idx), 128'd11);
    last_cycles = cycles;
    check("done_pulse", 128'(kif.done), 128'd1);
    check("busy_at_done", 128'(kif.busy), 128'd0);
    check("valid_at_done", 128'(kif.rk_valid), 128'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] a1, k2, rk;
    bit seen_done;
    a1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    k2 = 128'h000102030405060708090a0b0c0d0e0f;
    vecs[0] = '{a1, 0,  a1};
    vecs[1] = '{a1, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2] = '{a1, 2,  128'hf2c295f27a96b9435935807a7359f67f};
    vecs[3] = '{a1, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[4] = '{k2, 0,  k2};
    vecs[5] = '{k2, 10, 128'h13111d7fe3944a17f307a78b4d2b30c5};

    kif.start = 1'b0;
    kif.key = '0;
    kif.rk_ready = 1'b0;
`ifdef KEY_EXPAND_STORE_EN
    kif.rd_addr = '0;
`endif
    build_sbox();

    repeat (3) @(negedge clk);
    check("rst_rk", kif.rk, '0);
    check("rst_round", 128'(kif.rk_round), '0);
    check("rst_valid", 128'(kif.rk_valid), '0);
    check("rst_busy", 128'(kif.busy), '0);
    check("rst_done", 128'(kif.done), '0);
    rst = 1'b0;

    // Known-answer vectors; consecutive calls also exercise back-to-back starts.
    for (int v = 0; v < 6; v++) begin
      expand(vecs[v].key, 100, 0);
      check($sformatf("vec%0d", v), got_keys[vecs[v].round], vecs[v].expv);
      check("done_latency", 128'(last_cycles), 128'd11);
    end

    for (int n = 0; n < 6; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      expand(rk, 50, 0);
    end

    expand(a1, 60, 1);
    check("glitch_r10", got_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

`ifdef KEY_EXPAND_STORE_EN
    @(negedge clk);
    kif.rd_addr = 4'd10;
    @(negedge clk);
    check("store_10", kif.rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    kif.rd_addr = 4'd0;
    @(negedge clk);
    check("store_0", kif.rd_key, a1);
    kif.rd_addr = 4'd12;
    @(negedge clk);
    check("store_oob", kif.rd_key, '0);
`endif

    // Abort at round 6 with an asynchronous reset.
    @(negedge clk);
    kif.start = 1'b1;
    kif.key = a1;
    @(negedge clk);
    kif.start = 1'b0;
    kif.rk_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_at_r6", 128'(kif.rk_round), 128'd6);
    #2 rst = 1'b1;
    #1;
    check("abort_rk", kif.rk, '0);
    check("abort_round", 128'(kif.rk_round), '0);
    check("abort_valid", 128'(kif.rk_valid), '0);
    check("abort_busy", 128'(kif.busy), '0);
`ifdef KEY_EXPAND_STORE_EN
    check("abort_rdkey", kif.rd_key, '0);
`endif
    @(negedge clk);
    rst = 1'b0;
    kif.rk_ready = 1'b0;
    seen_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (kif.done) seen_done = 1;
    end
    check("no_done_after_abort", 128'(seen_done), 128'd0);
    expand(k2, 100, 0);
    check("after_abort_r10", got_keys[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_expand.md
# key_expand

Iterative AES-128 key-schedule engine. It takes a 128-bit cipher key and produces round keys 0..10 one per handshake, using a single SubWord instance on the RotWord'd last word of each round key. It sits between the key-load interface and the cipher round datapath, which consumes each round key through a valid/ready handshake.

## Interface
- BYTE, 8, bits per byte
- WORD, 32, bits per key-schedule word
- SENTENCE, 128, bits per key / round key
- ROUNDS, 10, number of expanded round keys after round key 0; fixed at 10 for AES-128
- clk  in  1  system clock; all state on rising edge
- rst  in  1  reset; one clock, asynchronous, active-high
- start  in  1  single-cycle request to begin expansion of `key`; ignored unless idle
- key  in  SENTENCE  cipher key; sampled only on an accepted `start`
- busy  out  1  high from the cycle after accepted `start` until `done`
- rk  out  SENTENCE  current round key; w0 in [127:96], w3 in [31:0]
- rk_round  out  4  index (0..10) of the key on `rk`
- rk_valid  out  1  `rk`/`rk_round` valid
- rk_ready  in  1  consumer accepts `rk` when `rk_valid & rk_ready`
- done  out  1  one-cycle pulse after round key 10 is accepted
- rd_addr  in  4  stored-key read index (only with KEY_EXPAND_STORE_EN)
- rd_key  out  SENTENCE  stored round key (only with KEY_EXPAND_STORE_EN)

## Operation
- FSM states:
  - IDLE → EXPAND on `start`.
  - EXPAND → DONE when round 10 is accepted.
  - DONE → IDLE unconditionally after one cycle.
- IDLE:
  - `rk_valid`=0, `busy`=0.
  - On `start`: load `rk`←`key`, `rk_round`←0, rcon←8'h01, `rk_valid`←1.
- EXPAND:
  - On an accepted handshake with `rk_round`<10, `rk` is updated with the next round key:
    - t = SubWord({w3[23:0], w3[31:24]}) ^ {rcon, 24'h0}
    - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'
    - `rk_round` increments.
    - rcon ← xtime(rcon) = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00). The sequence is 01,02,04,08,10,20,40,80,1b,36.
  - When round 10 is accepted, go to DONE: `rk_valid`←0.
- DONE:
  - `done`=1 for this single cycle; `busy` drops in the same cycle.
- Stall: while `rk_valid & !rk_ready`, `rk`, `rk_round` and rcon hold stable.
- `start` while busy or in DONE is ignored; the key is not resampled.
- Reset values: `rk`=0, `rk_round`=0, `rk_valid`=0, `busy`=0, `done`=0, rcon=8'h01, `rd_key`=0, all stored keys = 0; state=IDLE.
- Reset mid-expansion aborts immediately; no `done` pulse is produced.

## Timing
- `start` accepted in cycle N → `rk_valid`=1 with round 0 in cycle N+1.
- Handshake accepted in cycle M (round r<10) → round r+1 valid in cycle M+1. There are no bubbles.
- With `rk_ready` held high: rounds 0..10 appear on cycles N+1..N+11; `done` pulses at N+12; `start` is accepted again from N+13.
- The round computation is combinational from registered `rk`; SubWord path plus four XOR levels must close in one clock.

## Configuration
- KEY_EXPAND_STORE_EN defined:
  - Adds an 11×SENTENCE register file; entry r is written when round key r is accepted.
  - `rd_key` ← entry[`rd_addr`], registered with 1-cycle latency; `rd_addr`>10 returns 0.
  - Entries persist across expansions until overwritten or reset.
  - This provides the reverse-order keys needed for decryption.
- KEY_EXPAND_STORE_EN undefined:
  - No storage; `rd_addr`/`rd_key` ports are absent.
  - All other behaviour is identical.

## Test plan
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, `rk_ready`=1 → round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; `done` pulses exactly 11 cycles after round 0 appears.
- Same key with `rk_ready` toggling randomly → identical 11-key sequence; `rk` stable during every stall; no round skipped or repeated.
- `start` pulsed with a different key at round 4 → ignored; the original sequence completes unchanged.
- `rst` asserted at round 6 → all outputs 0 asynchronously; then key 000102030405060708090a0b0c0d0e0f → round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- Back-to-back expansions (new `start` in the first IDLE cycle after `done`) → second sequence starts at round 0 with the new key.
- STORE_EN build: after the A.1 expansion, `rd_addr`=10 → `rd_key` = d014f9a8…0ca6 on the next cycle; `rd_addr`=0 → 2b7e…4f3c; `rd_addr`=12 → 0.
